// File: rtl/surf_command_receiver.sv
// Serial command decoder for the TURF->SURF command line: start bit, buffer ID, event ID, stop bit.
// Optional event-ID continuity checking is built when SURF_CMD_SEQ_CHECK_EN is defined.
module surf_command_receiver #(
    parameter int EVENT_WIDTH = 32,
    parameter int BUF_WIDTH   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   CMD_i,
    output logic [EVENT_WIDTH-1:0] event_id_o,
    output logic [BUF_WIDTH-1:0]   buffer_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   frame_err_o,
    output logic                   seq_err_o
);

    localparam int N  = BUF_WIDTH + EVENT_WIDTH;
    localparam int CW = 6;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_STOP     = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   cmd_q;
    logic [N-1:0]           shift_q;
    logic [CW-1:0]          cnt_q;
    logic [EVENT_WIDTH-1:0] event_q;
    logic [BUF_WIDTH-1:0]   buffer_q;
    logic                   valid_q;
    logic                   frame_err_q;

`ifdef SURF_CMD_SEQ_CHECK_EN
    logic seq_err_q;
    logic have_ref_q;
    logic [EVENT_WIDTH-1:0] next_expected;

    // event_q already holds the last good event ID, so it doubles as the reference.
    assign next_expected = event_q + EVENT_WIDTH'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_err_q  <= 1'b0;
            have_ref_q <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            if (state_q == ST_STOP && !cmd_q) begin
                have_ref_q <= 1'b1;
                seq_err_q  <= have_ref_q && (shift_q[N-1:BUF_WIDTH] != next_expected);
            end
        end
    end

    assign seq_err_o = seq_err_q;
`else
    assign seq_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_WAIT_LOW;
            cmd_q       <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            event_q     <= '0;
            buffer_q    <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cmd_q       <= CMD_i;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_WAIT_LOW: begin
                    if (!cmd_q) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (cmd_q) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // LSB arrives first, so new bits enter at the top and walk down.
                    shift_q <= {cmd_q, shift_q[N-1:1]};
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (!cmd_q) begin
                        buffer_q <= shift_q[BUF_WIDTH-1:0];
                        event_q  <= shift_q[N-1:BUF_WIDTH];
                        valid_q  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_WAIT_LOW;
                    end
                end
                default: state_q <= ST_WAIT_LOW;
            endcase
        end
    end

    assign event_id_o  = event_q;
    assign buffer_o    = buffer_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q == ST_SHIFT) || (state_q == ST_STOP);

endmodule

// File: tb/tb_surf_command_receiver.sv
// Directed bench for surf_command_receiver: frame decode, latency, framing errors,
// back-to-back frames, reset mid-frame, stuck-high line and event-ID continuity.
module tb_surf_command_receiver;

    localparam int EW = 32;
    localparam int BW = 2;
    localparam int N  = EW + BW;
`ifdef SURF_CMD_SEQ_CHECK_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd = 1'b0;
    logic [EW-1:0] event_id;
    logic [BW-1:0] buffer;
    logic          valid;
    logic          busy;
    logic          frame_err;
    logic          seq_err;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int ferr_n     = 0;
    logic both_seen = 1'b0;

    int            got_cyc[$];
    logic [EW-1:0] got_evt[$];
    logic [BW-1:0] got_buf[$];
    logic          got_seq[$];
    logic [N-1:0]  exp_q[$];

    surf_command_receiver #(.EVENT_WIDTH(EW), .BUF_WIDTH(BW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .CMD_i      (cmd),
        .event_id_o (event_id),
        .buffer_o   (buffer),
        .valid_o    (valid),
        .busy_o     (busy),
        .frame_err_o(frame_err),
        .seq_err_o  (seq_err)
    );

    // clock / cycle count / pulse monitor
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid) begin
            got_cyc.push_back(cyc);
            got_evt.push_back(event_id);
            got_buf.push_back(buffer);
            got_seq.push_back(seq_err);
        end
        if (frame_err) ferr_n <= ferr_n + 1;
        if (valid && frame_err) both_seen <= 1'b1;
    end

    // driver tasks
    task automatic send_bit(input logic b);
        cmd = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [BW-1:0] b, input logic [EW-1:0] e,
                              input logic stop, output logic busy_mid);
        busy_mid = 1'b0;
        send_bit(1'b1);
        for (int i = 0; i < BW; i++) send_bit(b[i]);
        for (int i = 0; i < EW; i++) begin
            send_bit(e[i]);
            if (i == 8) busy_mid = busy;
        end
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        cmd = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        got_cyc.delete();
        got_evt.delete();
        got_buf.delete();
        got_seq.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset(input logic line);
        rst = 1'b1;
        cmd = line;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
        vectors++;
        if ({event_id, buffer, valid, busy, frame_err, seq_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got evt=%h buf=%h v=%b busy=%b ferr=%b seq=%b, want all 0",
                     event_id, buffer, valid, busy, frame_err, seq_err);
        end
    endtask

    task automatic test_single();
        int t0;
        int f0;
        logic bm;
        logic [N-1:0] exp;
        f0 = ferr_n;
        t0 = cyc;
        exp_q.push_back({32'h1234_5678, 2'b10});
        send_frame(2'b10, 32'h1234_5678, 1'b0, bm);
        idle(3);
        vectors++;
        if (bm !== 1'b1) begin
            miscompares++;
            $display("FAIL single_busy_mid: got %b want 1", bm);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_after: got %b want 0", busy);
        end
        vectors++;
        if (got_evt.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got %0d valid pulses want 1", got_evt.size());
        end else begin
            exp = exp_q.pop_front();
            vectors++;
            if (got_cyc[0] != t0 + 37) begin
                miscompares++;
                $display("FAIL single_latency: got cycle %0d want %0d", got_cyc[0], t0 + 37);
            end
            vectors++;
            if ({got_evt[0], got_buf[0]} !== exp) begin
                miscompares++;
                $display("FAIL single_data: got evt=%h buf=%h want evt=%h buf=%h",
                         got_evt[0], got_buf[0], exp[N-1:BW], exp[BW-1:0]);
            end
            vectors++;
            if (got_seq[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL single_seq: got %b want 0", got_seq[0]);
            end
        end
        vectors++;
        if (ferr_n != f0) begin
            miscompares++;
            $display("FAIL single_ferr: got %0d frame errors want 0", ferr_n - f0);
        end
    endtask

    task automatic test_frame_err();
        int f0;
        logic bm;
        clear_sb();
        f0 = ferr_n;
        send_frame(2'b01, 32'h5555_5555, 1'b1, bm);
        repeat (20) send_bit(1'b1);
        vectors++;
        if (ferr_n != f0 + 1) begin
            miscompares++;
            $display("FAIL ferr_pulse: got %0d frame errors want 1", ferr_n - f0);
        end
        vectors++;
        if (got_evt.size() != 0) begin
            miscompares++;
            $display("FAIL ferr_no_valid: got %0d valid pulses want 0", got_evt.size());
        end
        vectors++;
        if (event_id !== 32'h1234_5678 || buffer !== 2'b10) begin
            miscompares++;
            $display("FAIL ferr_hold: got evt=%h buf=%h want evt=12345678 buf=2", event_id, buffer);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ferr_wait_low_busy: got %b want 0", busy);
        end
        idle(2);
        send_frame(2'b11, 32'h1234_5679, 1'b0, bm);
        idle(3);
        vectors++;
        if (got_evt.size() != 1) begin
            miscompares++;
            $display("FAIL ferr_recover_count: got %0d want 1", got_evt.size());
        end else begin
            vectors++;
            if (got_evt[0] !== 32'h1234_5679 || got_buf[0] !== 2'b11 || got_seq[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL ferr_recover_data: got evt=%h buf=%h seq=%b want 12345679/3/0",
                         got_evt[0], got_buf[0], got_seq[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic bm;
        logic [N-1:0] exp;
        apply_reset(1'b0);
        idle(2);
        exp_q.push_back({32'd5, 2'd0});
        exp_q.push_back({32'd6, 2'd1});
        send_frame(2'd0, 32'd5, 1'b0, bm);
        send_frame(2'd1, 32'd6, 1'b0, bm);
        idle(3);
        vectors++;
        if (got_evt.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 2", got_evt.size());
        end else begin
            vectors++;
            if (got_cyc[1] - got_cyc[0] != N + 2) begin
                miscompares++;
                $display("FAIL b2b_spacing: got %0d cycles want %0d", got_cyc[1] - got_cyc[0], N + 2);
            end
            for (int i = 0; i < 2; i++) begin
                exp = exp_q.pop_front();
                vectors++;
                if ({got_evt[i], got_buf[i]} !== exp || got_seq[i] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_data%0d: got evt=%h buf=%h seq=%b want evt=%h buf=%h seq=0",
                             i, got_evt[i], got_buf[i], got_seq[i], exp[N-1:BW], exp[BW-1:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        logic bm;
        logic [10:0] bits;
        clear_sb();
        f0 = ferr_n;
        bits = 11'b101_1011_0111;
        send_bit(1'b1);
        for (int i = 0; i < 10; i++) send_bit(bits[i]);
        rst = 1'b1;
        #1;
        vectors++;
        if ({event_id, buffer, valid, busy, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got evt=%h buf=%h v=%b busy=%b ferr=%b want all 0",
                     event_id, buffer, valid, busy, frame_err);
        end
        cmd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);
        vectors++;
        if (got_evt.size() != 0 || ferr_n != f0) begin
            miscompares++;
            $display("FAIL midrst_no_pulse: got %0d valid %0d ferr want 0 0", got_evt.size(), ferr_n - f0);
        end
        send_frame(2'd1, 32'd7, 1'b0, bm);
        idle(3);
        vectors++;
        if (got_evt.size() != 1) begin
            miscompares++;
            $display("FAIL midrst_recover_count: got %0d want 1", got_evt.size());
        end else begin
            vectors++;
            if (got_evt[0] !== 32'd7 || got_buf[0] !== 2'd1 || got_seq[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_recover_data: got evt=%h buf=%h seq=%b want 7/1/0",
                         got_evt[0], got_buf[0], got_seq[0]);
            end
        end
    endtask

    task automatic test_stuck_high();
        logic bm;
        apply_reset(1'b1);
        repeat (100) send_bit(1'b1);
        vectors++;
        if (got_evt.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_high: got %0d valid busy=%b want 0 0", got_evt.size(), busy);
        end
        idle(2);
        send_frame(2'd3, 32'hFFFF_FFFF, 1'b0, bm);
        idle(3);
        vectors++;
        if (got_evt.size() != 1) begin
            miscompares++;
            $display("FAIL stuck_frame_count: got %0d want 1", got_evt.size());
        end else begin
            vectors++;
            if (got_evt[0] !== 32'hFFFF_FFFF || got_buf[0] !== 2'd3 || got_seq[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL stuck_frame_data: got evt=%h buf=%h seq=%b want ffffffff/3/0",
                         got_evt[0], got_buf[0], got_seq[0]);
            end
        end
    endtask

    task automatic test_seq();
        logic bm;
        clear_sb();
        send_frame(2'd0, 32'h0000_0000, 1'b0, bm);
        send_frame(2'd0, 32'h0000_0002, 1'b0, bm);
        idle(3);
        vectors++;
        if (got_evt.size() != 2) begin
            miscompares++;
            $display("FAIL seq_count: got %0d want 2", got_evt.size());
        end else begin
            vectors++;
            if (got_evt[0] !== 32'h0 || got_seq[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL seq_wrap: got evt=%h seq=%b want 0/0", got_evt[0], got_seq[0]);
            end
            vectors++;
            if (got_evt[1] !== 32'h2 || got_seq[1] !== SEQ_ON) begin
                miscompares++;
                $display("FAIL seq_gap: got evt=%h seq=%b want 2/%b", got_evt[1], got_seq[1], SEQ_ON);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_stuck_high();
        test_seq();
        vectors++;
        if (both_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_ferr_overlap: got %b want 0", both_seen);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
